// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the MIPS Avalon-MM arbiter and memory slave.
package mips_avalon_pkg;

    // Bus widths shared with the unified memory slave.
    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_BE_W   = MIPS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // One-hot grant vector, bit order {D, I}.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    // Encoding of the last-granted register (round-robin build only).
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    function automatic logic [1:0] state_to_grant(input arb_state_t s);
        case (s)
            GNT_I:   return GRANT_I;
            GNT_D:   return GRANT_D;
            default: return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mips_arb_watchdog.sv
// Stall watchdog: counts consecutive stalled granted cycles, pulses timeout
// on the cycle the count reaches TIMEOUT and keeps a sticky error flag.
// TIMEOUT = 0 disables the watchdog entirely.
module mips_arb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,          // granted and slave stalling this cycle
    input  logic clr,         // idle, completion or abort this cycle
    output logic timeout,     // this edge makes the count reach TIMEOUT
    output logic err_sticky
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_ON = (TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Next count (saturating, clear wins) and sticky error.
    always_comb begin
        cnt_d   = cnt_q;
        timeout = WD_ON && en && !clr && (cnt_q == CNT_LAST);
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | timeout;
    end

    // Counter and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Two-master (I-fetch, data) to one-slave Avalon-MM arbiter for the MIPS
// unified memory. Optional build macro: MIPS_ARB_ROUND_ROBIN_EN selects
// round-robin tie breaking; otherwise D wins every tie.
//
// Handshake: a master requests by holding read or write (write wins if both)
// with a stable command; the transfer completes on the first edge where the
// master is granted, still requesting, and sees waitrequest low. An ungranted
// requester always sees waitrequest high; a non-requester sees it low.
module mips_avalon_arbiter
    import mips_avalon_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    input  logic                i_write,
    input  logic [DATA_W-1:0]   i_writedata,
    input  logic [DATA_W/8-1:0] i_byteenable,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant,
    output logic                err,
    output arb_state_t          state_dbg
);

    arb_state_t state_q, state_d;

    logic req_i, req_d;
    logic gnt_req;      // the currently granted master is still requesting
    logic done;         // transfer completes at this edge
    logic abort;        // granted master withdrew its request
    logic tie_pick_d;   // D wins a simultaneous request in IDLE
    logic wd_en, wd_clr, wd_timeout;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    assign gnt_req = ((state_q == GNT_I) && req_i) || ((state_q == GNT_D) && req_d);
    assign done    = gnt_req && !s_waitrequest;
    assign abort   = (state_q != IDLE) && !gnt_req;

    assign wd_en  = gnt_req && s_waitrequest;
    assign wd_clr = (state_q == IDLE) || done || abort;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // Remember which master completed most recently.
    always_comb begin
        last_d = last_q;
        if (done) begin
            last_d = (state_q == GNT_D) ? LAST_D : LAST_I;
        end
    end

    // Last-granted register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= LAST_I;
        end else begin
            last_q <= last_d;
        end
    end

    assign tie_pick_d = (last_q == LAST_I);
`else
    assign tie_pick_d = 1'b1;
`endif

    // Next-state: arbitrate only from IDLE, every grant returns via IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = tie_pick_d ? GNT_D : GNT_I;
                end else if (req_d) begin
                    state_d = GNT_D;
                end else if (req_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (done || abort || wd_timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command mux to the slave and waitrequest back to the masters.
    always_comb begin
        s_address     = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = '0;
        s_byteenable  = '0;
        i_waitrequest = req_i;
        d_waitrequest = req_d;
        case (state_q)
            GNT_I: begin
                s_address     = i_address;
                s_read        = i_read & ~i_write;
                s_write       = i_write;
                s_writedata   = i_writedata;
                s_byteenable  = i_byteenable;
                i_waitrequest = s_waitrequest;
            end
            GNT_D: begin
                s_address     = d_address;
                s_read        = d_read & ~d_write;
                s_write       = d_write;
                s_writedata   = d_writedata;
                s_byteenable  = d_byteenable;
                d_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    // Read data goes to both masters; only the granted one is released.
    assign i_readdata = s_readdata;
    assign d_readdata = s_readdata;

    assign grant     = state_to_grant(state_q);
    assign state_dbg = state_q;

    mips_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .en         (wd_en),
        .clr        (wd_clr),
        .timeout    (wd_timeout),
        .err_sticky (err)
    );

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Randomized bench for mips_avalon_arbiter: two random Avalon masters, a
// 16-word memory slave with random waitrequest, periodic stuck-slave windows
// (watchdog, TIMEOUT=8) and reset pulses. Honours MIPS_ARB_ROUND_ROBIN_EN.
module tb_mips_avalon_arbiter;

    localparam int TB_TIMEOUT = 8;
    localparam int N_CYCLES   = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_address, d_address, s_address;
    logic        i_read, i_write, d_read, d_write, s_read, s_write;
    logic [31:0] i_writedata, d_writedata, s_writedata;
    logic [3:0]  i_byteenable, d_byteenable, s_byteenable;
    logic        i_waitrequest, d_waitrequest, s_waitrequest;
    logic [31:0] i_readdata, d_readdata, s_readdata;
    logic [1:0]  grant;
    logic        err;
    mips_avalon_pkg::arb_state_t dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave memory and the bench's own expected image of it.
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    // Transaction-level reference: who owns the bus, stall run length, error.
    int owner;       // 0 none, 1 I, 2 D
    int stall_run;
    bit exp_err;
    bit last_was_d;

    // Driver state.
    bit i_act, d_act;
    bit i_wr_seen, d_wr_seen;

    always #5 clk = ~clk;

    mips_avalon_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_writedata(i_writedata), .i_byteenable(i_byteenable),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .err(err), .state_dbg(dbg_state)
    );

    // Memory slave: combinational read, byte-masked write on accepted cycles.
    assign s_readdata = mem[s_address[5:2]];

    always @(posedge clk) begin
        if (s_write && !s_waitrequest) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteenable[b]) mem[s_address[5:2]][8*b +: 8] <= s_writedata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    task automatic new_cmd(output logic [31:0] a, output logic r, output logic w,
                           output logic [31:0] wd, output logic [3:0] be);
        int kind;
        a    = 32'hBFC0_0000 + 32'($urandom_range(0, 15)) * 32'd4;
        kind = int'($urandom_range(0, 15));
        r    = (kind <= 7);
        w    = (kind == 0) || (kind > 7);
        wd   = $urandom;
        be   = 4'($urandom_range(1, 15));
    endtask

    // Compare DUT outputs to the reference, then advance the reference by one edge.
    task automatic model_cycle();
        logic        o_rd, o_wr, o_req;
        logic [31:0] o_a, o_wd;
        logic [3:0]  o_be;
        logic [31:0] word;
        bit          rq_i, rq_d;

        rq_i = i_read || i_write;
        rq_d = d_read || d_write;
        o_a = '0; o_rd = 1'b0; o_wr = 1'b0; o_wd = '0; o_be = '0; o_req = 1'b0;
        if (owner == 1) begin
            o_a = i_address; o_wr = i_write; o_rd = i_read && !i_write;
            o_wd = i_writedata; o_be = i_byteenable; o_req = rq_i;
        end else if (owner == 2) begin
            o_a = d_address; o_wr = d_write; o_rd = d_read && !d_write;
            o_wd = d_writedata; o_be = d_byteenable; o_req = rq_d;
        end

        check("grant", 32'(grant), (owner == 1) ? 32'd1 : (owner == 2) ? 32'd2 : 32'd0);
        check("err", 32'(err), 32'(exp_err));
        check("s_address", s_address, o_a);
        check("s_read", 32'(s_read), 32'(o_rd));
        check("s_write", 32'(s_write), 32'(o_wr));
        check("s_writedata", s_writedata, o_wd);
        check("s_byteenable", 32'(s_byteenable), 32'(o_be));
        check("i_waitrequest", 32'(i_waitrequest), 32'((owner == 1) ? s_waitrequest : rq_i));
        check("d_waitrequest", 32'(d_waitrequest), 32'((owner == 2) ? s_waitrequest : rq_d));

        // Transfer completion: reads compare data, writes update the image.
        if (owner != 0 && o_req && !s_waitrequest) begin
            word = ref_mem[o_a[5:2]];
            if (o_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (o_be[b]) word[8*b +: 8] = o_wd[8*b +: 8];
                end
                ref_mem[o_a[5:2]] = word;
            end else if (owner == 1) begin
                check("i_readdata", i_readdata, word);
            end else begin
                check("d_readdata", d_readdata, word);
            end
        end

        // Advance the reference.
        if (rst) begin
            owner = 0; stall_run = 0; exp_err = 1'b0; last_was_d = 1'b0;
        end else if (owner == 0) begin
            stall_run = 0;
            if (rq_i && rq_d) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
                owner = last_was_d ? 1 : 2;
`else
                owner = 2;
`endif
            end else if (rq_d) owner = 2;
            else if (rq_i) owner = 1;
        end else if (!o_req) begin
            owner = 0; stall_run = 0;
        end else if (!s_waitrequest) begin
            last_was_d = (owner == 2);
            owner = 0; stall_run = 0;
        end else begin
            stall_run++;
            if (stall_run >= TB_TIMEOUT) begin
                exp_err = 1'b1; owner = 0; stall_run = 0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            mem[k] = $urandom;
            ref_mem[k] = mem[k];
        end
        rst = 1'b1; s_waitrequest = 1'b1;
        i_address = '0; i_read = 1'b0; i_write = 1'b0; i_writedata = '0; i_byteenable = '0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;
        i_act = 1'b0; d_act = 1'b0;
        owner = 0; stall_run = 0; exp_err = 1'b0; last_was_d = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge clk);
            i_wr_seen = i_waitrequest;
            d_wr_seen = d_waitrequest;
            model_cycle();
            @(posedge clk);
            #1;
            // Slave behaviour: random stall, stuck windows, occasional reset.
            rst = ((c % 600) == 400);
            if (rst || ((c % 200) >= 50 && (c % 200) < 70)) s_waitrequest = 1'b1;
            else s_waitrequest = ($urandom_range(0, 9) < 4);
            // Master I driver.
            if (i_act && !i_wr_seen) i_act = 1'b0;
            else if (i_act && $urandom_range(0, 39) == 0) i_act = 1'b0;
            if (!i_act && $urandom_range(0, 2) != 0) begin
                new_cmd(i_address, i_read, i_write, i_writedata, i_byteenable);
                i_act = 1'b1;
            end
            if (!i_act) begin i_read = 1'b0; i_write = 1'b0; end
            // Master D driver.
            if (d_act && !d_wr_seen) d_act = 1'b0;
            else if (d_act && $urandom_range(0, 39) == 0) d_act = 1'b0;
            if (!d_act && $urandom_range(0, 2) != 0) begin
                new_cmd(d_address, d_read, d_write, d_writedata, d_byteenable);
                d_act = 1'b1;
            end
            if (!d_act) begin d_read = 1'b0; d_write = 1'b0; end
        end

        // Final memory image must match the expected image.
        @(negedge clk);
        for (int k = 0; k < 16; k++) check("mem_final", mem[k], ref_mem[k]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
